mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester (if_*) and a load/store requester (dm_*).
//   clk, rst        : clock, asynchronous active-low reset
//   if_req/if_addr  : fetch request in; if_rdata/if_ready out
//   dm_req/dm_we/dm_size/dm_addr/dm_wdata : data request in; dm_rdata/dm_ready out
//   mem_valid/mem_we/mem_size/mem_addr/mem_wdata : registered memory request
//   mem_ready/mem_rdata : memory completion and read data
//   arb_busy        : high while a transaction is in flight
// Optional: define ARB_FAIRNESS_EN so that fetch gets every fourth grant
// while both sides keep requesting; otherwise dm has strict priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [2:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    localparam logic [2:0] FETCH_SIZE = 3'b010;

    state_e              state_q, state_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_we_q, mem_we_d;
    logic [2:0]          mem_size_q, mem_size_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                dm_ready_q, dm_ready_d;
    logic                arb_busy_q, arb_busy_d;
    logic                if_ok_c, dm_ok_c, fair_grant_c;

    // A request whose completion pulse is showing this cycle is already served.
    assign if_ok_c = if_req && !if_ready_q;
    assign dm_ok_c = dm_req && !dm_ready_q;

`ifdef ARB_FAIRNESS_EN
    logic [1:0] fair_cnt_q, fair_cnt_d;

    assign fair_grant_c = dm_req && if_ok_c && (fair_cnt_q == 2'd3);

    // Consecutive dm grants taken while fetch was waiting; saturates at 3.
    always_comb begin
        fair_cnt_d = fair_cnt_q;
        if (state_q == IDLE && state_d == BUSY_I) begin
            fair_cnt_d = 2'd0;
        end else if (state_q == IDLE && state_d == BUSY_D) begin
            if (!if_req)                 fair_cnt_d = 2'd0;
            else if (fair_cnt_q != 2'd3) fair_cnt_d = fair_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fair_cnt_q <= 2'd0;
        else      fair_cnt_q <= fair_cnt_d;
    end
`else
    assign fair_grant_c = 1'b0;
`endif

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= 3'b000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            arb_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            arb_busy_q  <= arb_busy_d;
        end
    end

    // Arbitration: a raw dm_req blocks fetch even in dm's own ready cycle,
    // so a continuously held dm_req keeps the port unless fairness steps in.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fair_grant_c)  state_d = BUSY_I;
                else if (dm_req) begin
                    if (dm_ok_c)   state_d = BUSY_D;
                end
                else if (if_ok_c)  state_d = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready)     state_d = IDLE;
            end
            default:               state_d = IDLE;
        endcase
    end

    // Output next-values: load the memory request on a grant, hold it until
    // mem_ready, then pulse the owner's ready and capture read data.
    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        arb_busy_d  = (state_d != IDLE);
        if (state_q == IDLE) begin
            if (state_d == BUSY_D) begin
                mem_valid_d = 1'b1;
                mem_we_d    = dm_we;
                mem_size_d  = dm_size;
                mem_addr_d  = dm_addr;
                mem_wdata_d = dm_wdata;
            end else if (state_d == BUSY_I) begin
                mem_valid_d = 1'b1;
                mem_we_d    = 1'b0;
                mem_size_d  = FETCH_SIZE;
                mem_addr_d  = if_addr;
                mem_wdata_d = '0;
            end
        end else if (mem_ready) begin
            mem_valid_d = 1'b0;
            if (state_q == BUSY_I) begin
                if_ready_d = 1'b1;
                if_rdata_d = mem_rdata;
            end else begin
                dm_ready_d = 1'b1;
                if (!mem_we_q) dm_rdata_d = mem_rdata;
            end
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign arb_busy  = arb_busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory
// requests and ready responses; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_t;

    typedef struct packed {
        logic        is_dm;
        logic [31:0] data;
    } rdy_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [2:0]  dm_size = 3'b000;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_valid;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        arb_busy;

    mem_t exp_mem[$];
    rdy_t exp_rdy[$];
    int   total = 0;
    int   bad = 0;

    int          mem_wait = 0;
    logic [31:0] mem_data = '0;
    bit          force_rdy = 1'b0;
    logic [31:0] last_dm = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory model: answers mem_wait cycles after it first sees mem_valid.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (force_rdy) begin
                mem_ready = 1'b1;
            end else if (mem_valid && !mem_ready) begin
                if (cnt >= mem_wait) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_data;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Monitor: checks each new memory request, its stability, and every ready pulse.
    initial begin
        mem_t cap;
        mem_t e;
        rdy_t r;
        bit   prev = 1'b0;
        cap = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b0;
            end else begin
                chk("arb_busy_vs_valid", 64'(arb_busy), 64'(mem_valid));
                if (mem_valid && !prev) begin
                    if (exp_mem.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_mem_req actual addr=%0h required none", mem_addr);
                    end else begin
                        e = exp_mem.pop_front();
                        chk("req_we",    64'(mem_we),    64'(e.we));
                        chk("req_size",  64'(mem_size),  64'(e.size));
                        chk("req_addr",  64'(mem_addr),  64'(e.addr));
                        chk("req_wdata", 64'(mem_wdata), 64'(e.wdata));
                    end
                    cap = '{we: mem_we, size: mem_size, addr: mem_addr, wdata: mem_wdata};
                end else if (mem_valid) begin
                    chk("stable_req", 64'({mem_we, mem_size, mem_addr, mem_wdata}), 64'(cap));
                end
                prev = mem_valid;
                if (if_ready || dm_ready) begin
                    if (exp_rdy.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_ready actual if=%0b dm=%0b required none", if_ready, dm_ready);
                    end else begin
                        r = exp_rdy.pop_front();
                        chk("ready_port", 64'({if_ready, dm_ready}), 64'({!r.is_dm, r.is_dm}));
                        chk("ready_data", 64'(r.is_dm ? dm_rdata : if_rdata), 64'(r.data));
                    end
                end
            end
        end
    end

    task automatic wait_ready(input bit dm, output int lat);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (dm ? dm_ready : if_ready) return;
        end
        total++; bad++;
        $display("FAIL timeout_ready actual none required dm=%0b", dm);
        lat = -1;
    endtask

    task automatic wait_any();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dm_ready || if_ready) return;
        end
        total++; bad++;
        $display("FAIL timeout_any actual none required ready");
    endtask

    task automatic push_mem(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        mem_t m;
        m = '{we: we, size: sz, addr: a, wdata: wd};
        exp_mem.push_back(m);
    endtask

    task automatic push_rdy(input logic is_dm, input logic [31:0] d);
        rdy_t r;
        r = '{is_dm: is_dm, data: d};
        exp_rdy.push_back(r);
    endtask

    initial begin
        int lat;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_busy",      64'(arb_busy),  64'd0);
        chk("rst_readies",   64'({if_ready, dm_ready}), 64'd0);
        chk("rst_fields",    64'({mem_we, mem_size, mem_addr}), 64'd0);
        chk("rst_rdata",     64'({if_rdata, dm_rdata}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single fetch, zero wait states
        mem_wait = 0; mem_data = 32'h0050_0093;
        push_mem(1'b0, 3'b010, 32'h10, 32'h0);
        push_rdy(1'b0, 32'h0050_0093);
        if_addr = 32'h10; if_req = 1'b1;
        wait_ready(1'b0, lat);
        if_req = 1'b0;
        chk("fetch_latency", 64'(lat), 64'd2);
        @(negedge clk);
        chk("fetch_pulse_one", 64'(if_ready), 64'd0);
        chk("fetch_rdata_held", 64'(if_rdata), 64'h0050_0093);

        // Simultaneous requests: dm load first, then fetch
        mem_data = 32'h1111_2222;
        push_mem(1'b0, 3'b010, 32'h200, 32'h0);
        push_mem(1'b0, 3'b010, 32'h24, 32'h0);
        push_rdy(1'b1, 32'h1111_2222);
        push_rdy(1'b0, 32'h3333_4444);
        dm_we = 1'b0; dm_size = 3'b010; dm_addr = 32'h200; dm_wdata = 32'h0;
        if_addr = 32'h24;
        dm_req = 1'b1; if_req = 1'b1;
        wait_ready(1'b1, lat);
        dm_req = 1'b0;
        mem_data = 32'h3333_4444;
        last_dm = 32'h1111_2222;
        wait_ready(1'b0, lat);
        if_req = 1'b0;
        @(negedge clk);

        // Store with 3 wait states; dm_rdata must keep the last load value
        mem_wait = 3; mem_data = 32'hBADB_AD00;
        push_mem(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
        push_rdy(1'b1, last_dm);
        dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        dm_req = 1'b1;
        wait_ready(1'b1, lat);
        dm_req = 1'b0;
        chk("store_latency", 64'(lat), 64'd5);
        @(negedge clk);
        chk("store_pulse_one", 64'(dm_ready), 64'd0);
        chk("store_rdata_kept", 64'(dm_rdata), 64'(last_dm));

        // Requester drops dm_req mid-transaction: it still completes
        mem_wait = 2; mem_data = 32'hCAFE_0001;
        push_mem(1'b0, 3'b000, 32'h88, 32'h5);
        push_rdy(1'b1, 32'hCAFE_0001);
        dm_we = 1'b0; dm_size = 3'b000; dm_addr = 32'h88; dm_wdata = 32'h5;
        dm_req = 1'b1;
        @(negedge clk);
        dm_req = 1'b0;
        wait_ready(1'b1, lat);
        chk("abort_latency", 64'(lat), 64'd3);
        last_dm = 32'hCAFE_0001;
        @(negedge clk);

        // Fetch request still high at the edge ending its ready cycle: no reissue
        mem_wait = 0; mem_data = 32'hAAAA_0001;
        push_mem(1'b0, 3'b010, 32'h80, 32'h0);
        push_rdy(1'b0, 32'hAAAA_0001);
        if_addr = 32'h80; if_req = 1'b1;
        wait_ready(1'b0, lat);
        @(negedge clk);
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_double_issue", 64'(arb_busy), 64'd0);

        // mem_ready while IDLE is ignored
        force_rdy = 1'b1;
        repeat (3) @(negedge clk);
        force_rdy = 1'b0;
        @(negedge clk);
        chk("idle_rdy_busy", 64'(arb_busy), 64'd0);
        chk("idle_rdy_rdata", 64'({if_rdata, dm_rdata}), 64'({32'hAAAA_0001, last_dm}));

        // Both held continuously: grant order
        mem_wait = 0; mem_data = 32'h0000_0077;
        dm_we = 1'b0; dm_size = 3'b010; dm_addr = 32'h300; dm_wdata = 32'h0;
        if_addr = 32'h400;
`ifdef ARB_FAIRNESS_EN
        for (int k = 0; k < 8; k++) begin
            if (k % 4 == 3) begin
                push_mem(1'b0, 3'b010, 32'h400, 32'h0); push_rdy(1'b0, 32'h77);
            end else begin
                push_mem(1'b0, 3'b010, 32'h300, 32'h0); push_rdy(1'b1, 32'h77);
            end
        end
        dm_req = 1'b1; if_req = 1'b1;
        for (int k = 0; k < 8; k++) wait_any();
        dm_req = 1'b0; if_req = 1'b0;
`else
        for (int k = 0; k < 4; k++) begin
            push_mem(1'b0, 3'b010, 32'h300, 32'h0); push_rdy(1'b1, 32'h77);
        end
        push_mem(1'b0, 3'b010, 32'h400, 32'h0); push_rdy(1'b0, 32'h77);
        dm_req = 1'b1; if_req = 1'b1;
        for (int k = 0; k < 4; k++) wait_ready(1'b1, lat);
        dm_req = 1'b0;
        wait_ready(1'b0, lat);
        if_req = 1'b0;
`endif
        last_dm = 32'h77;
        repeat (2) @(negedge clk);

        // Reset while BUSY_D: request dropped, no ready pulse
        mem_wait = 10; mem_data = 32'h1234_5678;
        push_mem(1'b0, 3'b010, 32'h500, 32'h0);
        dm_addr = 32'h500; dm_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", 64'(mem_valid), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst_valid_now", 64'(mem_valid), 64'd0);
        chk("rst_busy_now",  64'(arb_busy),  64'd0);
        chk("rst_dm_rdata",  64'(dm_rdata),  64'd0);
        dm_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", 64'(arb_busy), 64'd0);
        chk("post_rst_if_rdata", 64'(if_rdata), 64'd0);

        chk("exp_mem_drained", 64'(exp_mem.size()), 64'd0);
        chk("exp_rdy_drained", 64'(exp_rdy.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
